// File: rtl/nf_router_req_ctrl.sv
// Request-side controller of the data-bus router: decodes a master request to a
// one-hot slave select, waits for that slave's ack or a timeout, and returns a one-cycle ack.
module nf_router_req_ctrl #(
    parameter int Slave_n   = 4,
    parameter int Sel_lsb   = 16,
    parameter int Timeout_c = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               req_m,
    input  logic [31:0]        addr_m,
    input  logic               we_m,
    input  logic [31:0]        wd_m,
    output logic               ack_m,
    output logic               err_m,
    output logic [31:0]        rd_m,
    output logic [Slave_n-1:0] slave_sel,
    output logic [Slave_n-1:0] req_s,
    output logic [31:0]        addr_s,
    output logic               we_s,
    output logic [31:0]        wd_s,
    input  logic [Slave_n-1:0] ack_s,
    input  logic [31:0]        rd_mux
);

    localparam int IDX_W = (Slave_n > 1) ? $clog2(Slave_n) : 1;
    localparam int CNT_W = (Timeout_c > 1) ? $clog2(Timeout_c) : 1;
    localparam logic [IDX_W:0]   SLV_LIM  = (IDX_W + 1)'(Slave_n);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Timeout_c - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx;
    logic               mapped;
    logic [Slave_n-1:0] sel;
    logic               ack_hit;
    logic               timeout;

    // Address decode: index field must be in range and every bit above it zero.
    always_comb begin
        idx    = addr_m[Sel_lsb +: IDX_W];
        mapped = (addr_m[31:Sel_lsb+IDX_W] == '0) && ({1'b0, idx} < SLV_LIM);
        sel    = mapped ? (Slave_n'(1) << idx) : '0;
    end

    // Only the selected slave's ack counts; stray acks from other slaves are dropped.
    always_comb begin
        ack_hit = |(ack_s & slave_sel);
        timeout = (cnt == CNT_LAST);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (req_m) begin
                    state_n = mapped ? REQ : RESP;
                end
            end
            REQ: begin
                if (ack_hit || timeout) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt       <= '0;
            ack_m     <= 1'b0;
            err_m     <= 1'b0;
            rd_m      <= '0;
            slave_sel <= '0;
            req_s     <= '0;
            addr_s    <= '0;
            we_s      <= 1'b0;
            wd_s      <= '0;
        end else begin
            ack_m <= (state_n == RESP);
            case (state)
                IDLE: begin
                    if (req_m) begin
                        addr_s <= addr_m;
                        we_s   <= we_m;
                        wd_s   <= wd_m;
                        if (mapped) begin
                            slave_sel <= sel;
                            req_s     <= sel;
                            cnt       <= '0;
                        end else begin
                            err_m <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // An ack in the last allowed cycle takes priority over the timeout.
                    if (ack_hit) begin
                        if (!we_s) begin
                            rd_m <= rd_mux;
                        end
                        err_m <= 1'b0;
                        req_s <= '0;
                    end else if (timeout) begin
                        err_m <= 1'b1;
                        rd_m  <= '0;
                        req_s <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    slave_sel <= '0;
                    err_m     <= 1'b0;
                end
                default: begin
                    slave_sel <= '0;
                    req_s     <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/nf_router_req_ctrl.md
Name: nf_router_req_ctrl

Overview:
- Request-side controller of the data-bus router, directly upstream of the read-data mux.
- Accepts one load/store request at a time from the master (LSU) and decodes the address into a one-hot slave select.
- Drives the request to the selected slave, waits for that slave's ack, and captures the mux-selected read data (rd_mux) into a register.
- Returns a single-cycle ack, with an error flag for unmapped addresses or a slave timeout.

Parameters:
- Slave_n, 4, number of slaves; one-hot width of slave_sel and req_s/ack_s.
- Sel_lsb, 16, LSB of the slave index field in the address.
- Timeout_c, 16, maximum cycles spent waiting for a slave ack (≥2).

Ports:
- clk  input  1  system clock
- resetn  input  1  reset, asynchronous, active-low
- req_m  input  1  master request; held high by master until ack_m
- addr_m  input  32  master address
- we_m  input  1  1 = store, 0 = load
- wd_m  input  32  master write data
- ack_m  output  1  one-cycle transaction-done pulse
- err_m  output  1  valid with ack_m: unmapped address or timeout
- rd_m  output  32  registered read data to master
- slave_sel  output  Slave_n  one-hot select, to the read-data mux
- req_s  output  Slave_n  one-hot request to slaves
- addr_s  output  32  registered address broadcast to slaves
- we_s  output  1  registered write enable broadcast
- wd_s  output  32  registered write data broadcast
- ack_s  input  Slave_n  per-slave ack; may be combinational from req_s
- rd_mux  input  32  read data from the read-data mux (selected by slave_sel)

Behaviour:
- Reset (resetn low, async):
  - state = IDLE; timeout counter = 0.
  - ack_m, err_m, rd_m, slave_sel, req_s, addr_s, we_s, wd_s all 0.
  - A reset mid-transaction drops req_s immediately.
  - After reset is released, the first request is sampled on the first rising edge with resetn high.
- Decode:
  - Idx_w = $clog2(Slave_n); idx = addr_m[Sel_lsb +: Idx_w].
  - The address is mapped iff addr_m[31 : Sel_lsb+Idx_w] == 0 and idx < Slave_n.
  - Mapped: sel = 1 << idx.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - req_m is sampled only in this state.
  - On req_m=1: latch addr_m/we_m/wd_m into addr_s/we_s/wd_s.
    - Mapped: slave_sel = req_s = sel; counter = 0; → REQ.
    - Unmapped: err_m = 1; slave_sel and req_s stay 0; → RESP.
  - req_m=0: stay in IDLE.
- REQ:
  - slave_sel, req_s, addr_s, we_s and wd_s are held stable.
  - Only ack_s bits masked by slave_sel are honoured; ack on a non-selected bit is ignored.
  - Selected ack seen: if we_s = 0, rd_m ← rd_mux; if we_s = 1, rd_m holds. Then err_m = 0, req_s = 0, → RESP.
  - No ack and counter == Timeout_c-1: err_m = 1, rd_m ← 0, req_s = 0, → RESP.
  - Otherwise counter increments.
  - An ack in the final cycle wins over timeout.
- RESP:
  - ack_m = 1 for exactly this cycle; err_m is valid alongside it.
  - slave_sel stays set so the mux output stays stable; it clears on exit.
  - → IDLE.
  - err_m clears when leaving RESP; rd_m holds until the next capture.
- Latency, measured from the edge that samples req_m to the cycle ack_m is high:
  - Mapped with same-cycle ack: 2 cycles.
  - Ack k cycles into REQ: 2+k cycles.
  - Unmapped: 1 cycle.
  - Timeout: Timeout_c+1 cycles.
- Back-to-back: if req_m is still high in the IDLE cycle after RESP, a new transaction starts. Throughput is at most one transaction per 3 cycles.
- req_m dropping while in REQ is ignored; the transaction completes.
- Counter width is $clog2(Timeout_c); the counter never wraps because REQ is left at Timeout_c-1.

Test Plan:
- Load, slave 2: addr_m=0x0002_0010, we_m=0, ack_s[2] tied to req_s[2], rd_mux=0xCAFE_F00D → slave_sel=4'b0100 for 2 cycles; ack_m high 2 cycles after sampling; rd_m=0xCAFE_F00D; err_m=0.
- Store, slave 0: addr_m=0x0000_0004, wd_m=0x1234_5678, ack_s[0] delayed 3 cycles → wd_s=0x1234_5678 and we_s=1 held 4 cycles; ack_m once; rd_m unchanged.
- Unmapped: addr_m=0x0010_0000 → req_s never asserted; ack_m=1 and err_m=1 one cycle after sampling.
- Timeout: addr_m=0x0001_0000, ack_s=0 → req_s[1] high exactly 16 cycles, then ack_m=1, err_m=1, rd_m=0.
- Wrong-slave ack: select slave 3; pulse ack_s[1], then ack_s[3] 2 cycles later → completion only on ack_s[3]; rd_m = rd_mux value at that edge.
- Reset mid-REQ: assert resetn=0 while req_s=4'b0010 → req_s and all outputs 0 immediately; after release, a request to slave 1 completes normally with ack_m after 2 cycles.
